// File: rtl/proc_pkg.sv
// Shared types and constants for the 10-bit multi-cycle processor control unit.
package proc_pkg;

  localparam int DATA_W = 10;

  // Instruction field boundaries: IR[9:6] opcode, IR[5:3] Rx, IR[2:0] Ry.
  localparam int OP_HI = 9;
  localparam int OP_LO = 6;
  localparam int RX_HI = 5;
  localparam int RX_LO = 3;
  localparam int RY_HI = 2;
  localparam int RY_LO = 0;

  // Opcodes 8-15 have no name on purpose: they decode as NOP.
  typedef enum logic [3:0] {
    OP_LOAD = 4'd0,
    OP_MOV  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_INV  = 4'd4,
    OP_NEG  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SHL  = 4'd7
  } opcode_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_INV = 3'd2,
    ALU_NEG = 3'd3,
    ALU_SHR = 3'd4,
    ALU_SHL = 3'd5
  } alu_op_t;

  // Register index to one-hot enable/select vector.
  function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
    logic [7:0] r;
    r = 8'b0000_0001 << idx;
    return r;
  endfunction

endpackage

// File: rtl/proc_step_controller_ctrl_decode.sv
// Combinational control-word decoder: (state, IR, STEP) -> datapath controls
// and next state. Load enables and Done are qualified by step_i; bus selects
// and ALU op depend on state/IR only so the bus is stable for the whole state.
module ctrl_decode
  import proc_pkg::*;
(
  input  state_t                  state_i,
  input  logic [DATA_W-1:0]       ir_i,
  input  logic                    step_i,
  output logic [7:0]              rin_o,
  output logic [7:0]              rout_o,
  output logic                    ain_o,
  output logic                    gin_o,
  output logic                    gout_o,
  output logic                    ext_o,
  output alu_op_t                 alu_op_o,
  output logic                    done_o,
  output state_t                  next_state_o
);

  opcode_t    opcode;
  logic [7:0] rx_oh;
  logic [7:0] ry_oh;
  state_t     adv_state;

  assign opcode = opcode_t'(ir_i[OP_HI:OP_LO]);
  assign rx_oh  = reg_onehot(ir_i[RX_HI:RX_LO]);
  assign ry_oh  = reg_onehot(ir_i[RY_HI:RY_LO]);

  // Per-state micro-operations; unexpected state/opcode pairs go back to T0 idle.
  always_comb begin
    rin_o     = 8'h00;
    rout_o    = 8'h00;
    ain_o     = 1'b0;
    gin_o     = 1'b0;
    gout_o    = 1'b0;
    ext_o     = 1'b0;
    alu_op_o  = ALU_ADD;
    done_o    = 1'b0;
    adv_state = T0;
    case (state_i)
      T0: begin
        adv_state = T1;
      end
      T1: begin
        case (opcode)
          OP_LOAD: begin
            ext_o  = 1'b1;
            rin_o  = step_i ? rx_oh : 8'h00;
            done_o = step_i;
          end
          OP_MOV: begin
            rout_o = ry_oh;
            rin_o  = step_i ? rx_oh : 8'h00;
            done_o = step_i;
          end
          OP_ADD, OP_SUB: begin
            rout_o    = rx_oh;
            ain_o     = step_i;
            adv_state = T2;
          end
          OP_INV: begin
            rout_o    = ry_oh;
            gin_o     = step_i;
            alu_op_o  = ALU_INV;
            adv_state = T2;
          end
          OP_NEG: begin
            rout_o    = ry_oh;
            gin_o     = step_i;
            alu_op_o  = ALU_NEG;
            adv_state = T2;
          end
          OP_SHR: begin
            rout_o    = ry_oh;
            gin_o     = step_i;
            alu_op_o  = ALU_SHR;
            adv_state = T2;
          end
          OP_SHL: begin
            rout_o    = ry_oh;
            gin_o     = step_i;
            alu_op_o  = ALU_SHL;
            adv_state = T2;
          end
          default: begin
            done_o = step_i;
          end
        endcase
      end
      T2: begin
        case (opcode)
          OP_ADD, OP_SUB: begin
            rout_o    = ry_oh;
            gin_o     = step_i;
            alu_op_o  = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
            adv_state = T3;
          end
          OP_INV, OP_NEG, OP_SHR, OP_SHL: begin
            gout_o = 1'b1;
            rin_o  = step_i ? rx_oh : 8'h00;
            done_o = step_i;
          end
          default: begin
            adv_state = T0;
          end
        endcase
      end
      T3: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          gout_o = 1'b1;
          rin_o  = step_i ? rx_oh : 8'h00;
          done_o = step_i;
        end
      end
      default: begin
        adv_state = T0;
      end
    endcase
    next_state_o = step_i ? adv_state : state_i;
  end

endmodule

// File: rtl/proc_step_controller.sv
// Multi-cycle control unit: holds the state register, IR and retired-instruction
// counter, and drives the datapath control word produced by ctrl_decode.
// STEP is a one-cycle pulse; the state advances only in cycles where STEP=1.
module proc_step_controller #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STEP,
  input  logic [DATA_W-1:0] Data_in,
  output logic [7:0]        Rin,
  output logic [7:0]        Rout,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic              Ext,
  output logic [2:0]        ALU_op,
  output logic              Done,
  output logic [DATA_W-1:0] IR,
  output logic [1:0]        State,
  output logic [CNT_W-1:0]  Icount
);
  import proc_pkg::*;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]    icount_q, icount_d;

  logic                step_qual;
  logic [7:0]          dec_rin, dec_rout;
  logic                dec_ain, dec_gin, dec_gout, dec_ext, dec_done;
  alu_op_t             dec_alu_op;
  state_t              dec_next_state;

  // Reset wins over STEP, so a coincident STEP must not fire any load enable.
  assign step_qual = STEP & ~RST;

  ctrl_decode u_decode (
    .state_i      (state_q),
    .ir_i         (ir_q),
    .step_i       (step_qual),
    .rin_o        (dec_rin),
    .rout_o       (dec_rout),
    .ain_o        (dec_ain),
    .gin_o        (dec_gin),
    .gout_o       (dec_gout),
    .ext_o        (dec_ext),
    .alu_op_o     (dec_alu_op),
    .done_o       (dec_done),
    .next_state_o (dec_next_state)
  );

  // Control outputs, forced idle while reset is asserted.
  always_comb begin
    Rin    = 8'h00;
    Rout   = 8'h00;
    Ain    = 1'b0;
    Gin    = 1'b0;
    Gout   = 1'b0;
    Ext    = 1'b0;
    ALU_op = ALU_ADD;
    Done   = 1'b0;
    if (!RST) begin
      Rin    = dec_rin;
      Rout   = dec_rout;
      Ain    = dec_ain;
      Gin    = dec_gin;
      Gout   = dec_gout;
      Ext    = dec_ext;
      ALU_op = dec_alu_op;
      Done   = dec_done;
    end
  end

  // Next-state values for state, IR capture in T0, and retire counting.
  always_comb begin
    state_d  = dec_next_state;
    ir_d     = ir_q;
    icount_d = icount_q;
    if (state_q == T0 && step_qual) begin
      ir_d = Data_in;
    end
    if (Done) begin
      icount_d = icount_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State, IR and counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= T0;
      ir_q     <= '0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      icount_q <= icount_d;
    end
  end

  assign IR     = ir_q;
  assign State  = state_q;
  assign Icount = icount_q;

endmodule
